// File: rtl/ram512x32_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package ram512x32_arb_pkg;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} arb_state_t;

  localparam logic PORT_IBUS = 1'b0;
  localparam logic PORT_DBUS = 1'b1;

  localparam int RAM_AW = 9;
  localparam int RAM_DW = 32;

endpackage

// File: rtl/ram512x32_arb_arb2_rr.sv
// Two-input arbiter: round-robin (RR=1) or fixed priority to index 1 (RR=0).
// Combinational grant; last-granted index is registered whenever the grant is taken.
module arb2_rr
  import ram512x32_arb_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       any
);

  logic last_q;

  always_comb begin
    any = |req;
    gnt = PORT_IBUS;
    if (req[PORT_DBUS] && req[PORT_IBUS]) begin
      // Under contention, round-robin hands the grant to whoever did not win last.
      gnt = RR ? ~last_q : PORT_DBUS;
    end else if (req[PORT_DBUS]) begin
      gnt = PORT_DBUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DBUS;
    end else if (take) begin
      last_q <= gnt;
    end
  end

endmodule

// File: rtl/ram512x32_arb.sv
// Sequencer for the shared 512x32 SRAM: one access issued in IDLE, acked in RESP.
// Latency 1 cycle from issue to ack; one access per 2 cycles; losers hold stb.
module ram512x32_arb
  import ram512x32_arb_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              ibus_stb_i,
  input  logic [RAM_AW-1:0] ibus_adr_i,
  output logic              ibus_ack_o,
  output logic [RAM_DW-1:0] ibus_rdat_o,
  input  logic              dbus_stb_i,
  input  logic              dbus_we_i,
  input  logic [3:0]        dbus_sel_i,
  input  logic [RAM_AW-1:0] dbus_adr_i,
  input  logic [RAM_DW-1:0] dbus_wdat_i,
  output logic              dbus_ack_o,
  output logic [RAM_DW-1:0] dbus_rdat_o,
  output logic              ram_wen_o,
  output logic [3:0]        ram_sel_o,
  output logic [RAM_AW-1:0] ram_adr_o,
  output logic [RAM_DW-1:0] ram_dat_o,
  input  logic [RAM_DW-1:0] ram_dat_i
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              grant_q;
  logic              gnt;
  logic              any;
  logic              take;
  logic              wen;
  logic [3:0]        sel;
  logic [RAM_AW-1:0] adr;
  logic [RAM_DW-1:0] dat;

  arb2_rr #(
    .RR(RR)
  ) u_arb (
    .clk  (clk_i),
    .rst_n(rst_in),
    .req  ({dbus_stb_i, ibus_stb_i}),
    .take (take),
    .gnt  (gnt),
    .any  (any)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    wen     = 1'b0;
    sel     = '0;
    adr     = '0;
    dat     = '0;
    case (state_q)
      IDLE: begin
        if (any) begin
          take    = 1'b1;
          state_d = RESP;
          if (gnt == PORT_DBUS) begin
            adr = dbus_adr_i;
            if (dbus_we_i) begin
              wen = 1'b1;
              sel = dbus_sel_i;
              dat = dbus_wdat_i;
            end
          end else begin
            adr = ibus_adr_i;
          end
        end
      end
      RESP: begin
        // The acked master still holds stb this cycle, so nothing may issue here.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      grant_q <= PORT_IBUS;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q <= gnt;
      end
    end
  end

  // Write strobes are gated by reset directly so nothing can be written while it is held.
  assign ram_wen_o   = wen & rst_in;
  assign ram_sel_o   = sel & {4{rst_in}};
  assign ram_adr_o   = adr;
  assign ram_dat_o   = dat;

  assign ibus_ack_o  = (state_q == RESP) && (grant_q == PORT_IBUS);
  assign dbus_ack_o  = (state_q == RESP) && (grant_q == PORT_DBUS);
  assign ibus_rdat_o = ram_dat_i;
  assign dbus_rdat_o = ram_dat_i;

endmodule

// File: tb/tb_ram512x32_arb.sv
// Bench for ram512x32_arb: behavioural SRAM, scoreboard of expected acks, RR and fixed-priority instances.
module tb_ram512x32_arb;

  typedef struct {
    bit          port;
    bit          chk;
    logic [31:0] dat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ibus_stb;
  logic [8:0]  ibus_adr;
  logic        ibus_ack;
  logic [31:0] ibus_rdat;
  logic        dbus_stb;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [8:0]  dbus_adr;
  logic [31:0] dbus_wdat;
  logic        dbus_ack;
  logic [31:0] dbus_rdat;
  logic        ram_wen;
  logic [3:0]  ram_sel;
  logic [8:0]  ram_adr;
  logic [31:0] ram_wdat;
  logic [31:0] ram_rdat;

  logic        fp_ibus_stb;
  logic        fp_ibus_ack;
  logic [31:0] fp_ibus_rdat;
  logic        fp_dbus_stb;
  logic        fp_dbus_ack;
  logic [31:0] fp_dbus_rdat;
  logic        fp_ram_wen;
  logic [3:0]  fp_ram_sel;
  logic [8:0]  fp_ram_adr;
  logic [31:0] fp_ram_wdat;
  logic [31:0] fp_ram_rdat;

  logic [31:0] mem [512];
  exp_t        sb[$];
  int          checks;
  int          fails;
  int          cyc;
  bit          gap_chk;
  bit          gap_first;
  int          last_ack_cyc;

  ram512x32_arb #(.RR(1'b1)) dut (
    .clk_i(clk), .rst_in(rst_n),
    .ibus_stb_i(ibus_stb), .ibus_adr_i(ibus_adr), .ibus_ack_o(ibus_ack), .ibus_rdat_o(ibus_rdat),
    .dbus_stb_i(dbus_stb), .dbus_we_i(dbus_we), .dbus_sel_i(dbus_sel), .dbus_adr_i(dbus_adr),
    .dbus_wdat_i(dbus_wdat), .dbus_ack_o(dbus_ack), .dbus_rdat_o(dbus_rdat),
    .ram_wen_o(ram_wen), .ram_sel_o(ram_sel), .ram_adr_o(ram_adr), .ram_dat_o(ram_wdat),
    .ram_dat_i(ram_rdat)
  );

  ram512x32_arb #(.RR(1'b0)) fp_dut (
    .clk_i(clk), .rst_in(rst_n),
    .ibus_stb_i(fp_ibus_stb), .ibus_adr_i(9'h003), .ibus_ack_o(fp_ibus_ack), .ibus_rdat_o(fp_ibus_rdat),
    .dbus_stb_i(fp_dbus_stb), .dbus_we_i(1'b0), .dbus_sel_i(4'b0000), .dbus_adr_i(9'h004),
    .dbus_wdat_i(32'h0), .dbus_ack_o(fp_dbus_ack), .dbus_rdat_o(fp_dbus_rdat),
    .ram_wen_o(fp_ram_wen), .ram_sel_o(fp_ram_sel), .ram_adr_o(fp_ram_adr), .ram_dat_o(fp_ram_wdat),
    .ram_dat_i(fp_ram_rdat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
      end
    end
    ram_rdat <= mem[ram_adr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h need=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!gap_chk) gap_first = 1'b1;
      if (ibus_ack && dbus_ack) begin
        chk("dual_ack", 32'(ibus_ack & dbus_ack), 32'd0);
      end else if (ibus_ack || dbus_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {31'd0, dbus_ack}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("ack_port", {31'd0, dbus_ack}, {31'd0, e.port});
          if (e.chk) chk("rdat", e.port ? dbus_rdat : ibus_rdat, e.dat);
        end
        if (gap_chk) begin
          if (!gap_first) chk("ack_gap", 32'(cyc - last_ack_cyc), 32'd2);
          gap_first    = 1'b0;
          last_ack_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_ack(input bit port);
    int  t;
    bit  seen;
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 40) begin
      @(negedge clk);
      t++;
      seen = port ? dbus_ack : ibus_ack;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL ack_timeout port=%0d got=none need=ack", port);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ibus_run(input int n, input logic [8:0] adr);
    ibus_adr = adr;
    ibus_stb = 1'b1;
    for (int k = 0; k < n; k++) wait_ack(1'b0);
    ibus_stb = 1'b0;
  endtask

  task automatic dbus_run(input int n, input logic we, input logic [3:0] sel,
                          input logic [8:0] adr, input logic [31:0] wdat);
    dbus_we   = we;
    dbus_sel  = sel;
    dbus_adr  = adr;
    dbus_wdat = wdat;
    dbus_stb  = 1'b1;
    for (int k = 0; k < n; k++) wait_ack(1'b1);
    dbus_stb = 1'b0;
  endtask

  task automatic ibus_rd(input logic [8:0] adr, input logic [31:0] exp);
    sb.push_back('{1'b0, 1'b1, exp});
    ibus_run(1, adr);
  endtask

  task automatic dbus_wr(input logic [3:0] sel, input logic [8:0] adr, input logic [31:0] wdat);
    sb.push_back('{1'b1, 1'b0, 32'h0});
    dbus_run(1, 1'b1, sel, adr, wdat);
  endtask

  task automatic dbus_rd(input logic [8:0] adr, input logic [31:0] exp);
    sb.push_back('{1'b1, 1'b1, exp});
    dbus_run(1, 1'b0, 4'b0000, adr, 32'h0);
  endtask

  initial begin
    int n_i;
    int n_d;
    bit seen;
    checks = 0; fails = 0; gap_chk = 1'b0; last_ack_cyc = 0;
    rst_n = 1'b0;
    ibus_stb = 1'b0; ibus_adr = '0;
    dbus_stb = 1'b0; dbus_we = 1'b0; dbus_sel = '0; dbus_adr = '0; dbus_wdat = '0;
    fp_ibus_stb = 1'b0; fp_dbus_stb = 1'b0; fp_ram_rdat = 32'h5A5A_A5A5;

    @(negedge clk);
    chk("rst_ibus_ack", {31'd0, ibus_ack}, 32'd0);
    chk("rst_dbus_ack", {31'd0, dbus_ack}, 32'd0);
    chk("rst_wen", {31'd0, ram_wen}, 32'd0);
    chk("rst_sel", {28'd0, ram_sel}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_adr", {23'd0, ram_adr}, 32'd0);
    chk("idle_dat", ram_wdat, 32'd0);
    @(posedge clk); #1;

    // Preload through the data bus.
    dbus_wr(4'b1111, 9'h010, 32'hDEAD_BEEF);
    dbus_wr(4'b1111, 9'h1FF, 32'hAABB_CCDD);

    // Single ibus read with cycle-accurate observation.
    @(posedge clk); #1;
    ibus_adr = 9'h010; ibus_stb = 1'b1;
    sb.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("t1_adr", {23'd0, ram_adr}, 32'h010);
    chk("t1_wen", {31'd0, ram_wen}, 32'd0);
    @(negedge clk);
    chk("t1_ack", {31'd0, ibus_ack}, 32'd1);
    @(posedge clk); #1;
    ibus_stb = 1'b0;
    @(negedge clk);
    chk("t1_ack_low", {31'd0, ibus_ack}, 32'd0);

    // Partial-byte write over 0xAABBCCDD.
    @(posedge clk); #1;
    dbus_we = 1'b1; dbus_sel = 4'b0101; dbus_adr = 9'h1FF; dbus_wdat = 32'h1122_3344; dbus_stb = 1'b1;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    @(negedge clk);
    chk("t2_wen", {31'd0, ram_wen}, 32'd1);
    chk("t2_sel", {28'd0, ram_sel}, 32'h5);
    chk("t2_adr", {23'd0, ram_adr}, 32'h1FF);
    chk("t2_dat", ram_wdat, 32'h1122_3344);
    @(negedge clk);
    chk("t2_wen_off", {31'd0, ram_wen}, 32'd0);
    chk("t2_ack", {31'd0, dbus_ack}, 32'd1);
    @(posedge clk); #1;
    dbus_stb = 1'b0;
    dbus_rd(9'h1FF, 32'hAA22_CC44);

    // Reset during RESP of a dbus read.
    @(posedge clk); #1;
    dbus_we = 1'b0; dbus_adr = 9'h010; dbus_stb = 1'b1;
    @(posedge clk); #1;
    chk("t5_ack_before", {31'd0, dbus_ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_ack_drop", {31'd0, dbus_ack}, 32'd0);
    dbus_we = 1'b1; dbus_sel = 4'b1111; dbus_adr = 9'h020; dbus_wdat = 32'h1234_5678;
    ibus_adr = 9'h1FF; ibus_stb = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_rst_wen", {31'd0, ram_wen}, 32'd0);
      chk("t5_rst_sel", {28'd0, ram_sel}, 32'd0);
    end
    sb.push_back('{1'b0, 1'b1, 32'hAA22_CC44});
    sb.push_back('{1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_issue_adr", {23'd0, ram_adr}, 32'h1FF);
    @(negedge clk);
    chk("t5_ibus_ack", {31'd0, ibus_ack}, 32'd1);
    @(posedge clk); #1;
    ibus_stb = 1'b0;
    dbus_run(1, 1'b1, 4'b1111, 9'h020, 32'h1234_5678);
    dbus_rd(9'h020, 32'h1234_5678);

    // Round-robin contention: ibus, dbus, ibus, dbus, two cycles apart.
    sb.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF});
    sb.push_back('{1'b1, 1'b1, 32'hAA22_CC44});
    sb.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF});
    sb.push_back('{1'b1, 1'b1, 32'hAA22_CC44});
    @(posedge clk); #1;
    gap_chk = 1'b1;
    fork
      ibus_run(2, 9'h010);
      dbus_run(2, 1'b0, 4'b0000, 9'h1FF, 32'h0);
    join
    gap_chk = 1'b0;

    // Boundary words.
    dbus_wr(4'b1111, 9'h000, 32'h0BAD_F00D);
    dbus_wr(4'b1111, 9'h1FF, 32'hCAFE_0123);
    dbus_rd(9'h000, 32'h0BAD_F00D);
    dbus_rd(9'h1FF, 32'hCAFE_0123);
    ibus_rd(9'h000, 32'h0BAD_F00D);

    // Fixed-priority instance: dbus always wins while held.
    @(posedge clk); #1;
    fp_ibus_stb = 1'b1; fp_dbus_stb = 1'b1;
    n_i = 0; n_d = 0;
    repeat (20) begin
      @(negedge clk);
      if (fp_ibus_ack) n_i++;
      if (fp_dbus_ack) n_d++;
    end
    chk("fp_ibus_acks", 32'(n_i), 32'd0);
    chk("fp_dbus_acks", 32'(n_d), 32'd10);
    @(posedge clk); #1;
    fp_dbus_stb = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 5 && !seen; t++) begin
      @(negedge clk);
      if (fp_ibus_ack) begin
        seen = 1'b1;
        chk("fp_ibus_rdat", fp_ibus_rdat, 32'h5A5A_A5A5);
      end
    end
    chk("fp_ibus_served", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    fp_ibus_stb = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
